// File: rtl/pipeline_adder_pkg.sv
// Shared helpers for pipeline_adder_tree: tree geometry and operand/result resizing.
// Helpers work on a MAX_W-bit container; callers size-cast to their real width.
package pipeline_adder_pkg;

    localparam int MAX_W = 64;

    // Number of adder levels needed to reduce n operands to one.
    function automatic int levels_of(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Operand slots after padding up to a power of two.
    function automatic int pow2_of(input int n);
        return 1 << levels_of(n);
    endfunction

    // Sign- or zero-extend the low 'width' bits of value.
    function automatic logic [MAX_W-1:0] extend_to_sum(input logic [MAX_W-1:0] value,
                                                       input int width,
                                                       input logic is_signed);
        logic [MAX_W-1:0] r;
        logic             fill;
        fill = 1'b0;
        for (int b = 0; b < MAX_W; b++) begin
            if (b == width - 1) fill = is_signed & value[b];
            r[b] = (b < width) ? value[b] : fill;
        end
        return r;
    endfunction

    // True when the sum_w-bit value does not fit in out_w bits.
    function automatic logic resize_clamped(input logic [MAX_W-1:0] sum,
                                            input int sum_w,
                                            input int out_w,
                                            input logic is_signed);
        logic top;
        logic hit;
        top = 1'b0;
        hit = 1'b0;
        for (int b = 0; b < MAX_W; b++) begin
            if (b == sum_w - 1) top = sum[b];
        end
        for (int b = 0; b < MAX_W; b++) begin
            if (b < sum_w) begin
                if (is_signed && (b >= out_w - 1) && (sum[b] != top)) hit = 1'b1;
                if (!is_signed && (b >= out_w) && sum[b]) hit = 1'b1;
            end
        end
        return (out_w < sum_w) ? hit : 1'b0;
    endfunction

    // Resize the sum; the caller keeps the low out_w bits. Without saturation
    // that is plain truncation, with it an out-of-range value becomes max/min.
    function automatic logic [MAX_W-1:0] resize_out(input logic [MAX_W-1:0] sum,
                                                    input int sum_w,
                                                    input int out_w,
                                                    input logic is_signed,
                                                    input logic sat_en);
        logic [MAX_W-1:0] r;
        logic             neg;
        r   = sum;
        neg = 1'b0;
        if (sat_en && resize_clamped(sum, sum_w, out_w, is_signed)) begin
            for (int b = 0; b < MAX_W; b++) begin
                if (b == sum_w - 1) neg = is_signed & sum[b];
            end
            for (int b = 0; b < MAX_W; b++) begin
                if (b < out_w - 1)       r[b] = !neg;
                else if (b == out_w - 1) r[b] = is_signed ? neg : 1'b1;
                else                     r[b] = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pipeline_adder_tree_stage.sv
// One level of the adder tree: COUNT pairwise adders plus the sum/tag/valid
// register, which loads whenever it is empty or the next level is taking its beat.
module pipeline_adder_tree_stage
    import pipeline_adder_pkg::*;
#(
    parameter int WIDTH     = 13,
    parameter int COUNT     = 1,
    parameter int TAG_WIDTH = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2*COUNT*WIDTH-1:0] prev_sum,
    input  logic [TAG_WIDTH-1:0]     prev_tag,
    input  logic                     prev_valid,
    input  logic                     next_ready,
    output logic [COUNT*WIDTH-1:0]   sum,
    output logic [TAG_WIDTH-1:0]     tag,
    output logic                     valid
);

    logic [COUNT*WIDTH-1:0] pair_sum;
    logic                   load;

    assign load = !valid || next_ready;

    // Adder row: slot j = previous slot 2j + previous slot 2j+1, wrapping at WIDTH.
    always_comb begin
        pair_sum = '0;
        for (int j = 0; j < COUNT; j++) begin
            pair_sum[j*WIDTH +: WIDTH] = prev_sum[2*j*WIDTH +: WIDTH]
                                       + prev_sum[(2*j+1)*WIDTH +: WIDTH];
        end
    end

    // Level register; an empty level accepts even while downstream is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            sum   <= '0;
            tag   <= '0;
        end else if (load) begin
            valid <= prev_valid;
            sum   <= pair_sum;
            tag   <= prev_tag;
        end
    end

endmodule

// File: rtl/pipeline_adder_tree.sv
// Pipelined binary adder tree with valid/ready flow control, sideband tag and
// output resizing. Optional saturation on narrowing: define PIPELINE_ADDER_TREE_SAT_EN.
module pipeline_adder_tree
    import pipeline_adder_pkg::*;
#(
    parameter int NUMBERS_AMOUNT = 8,
    parameter int NUMBER_WIDTH   = 10,
    parameter int SUM_WIDTH      = NUMBER_WIDTH + $clog2(NUMBERS_AMOUNT),
    parameter int OUT_WIDTH      = SUM_WIDTH,
    parameter int SIGNED         = 0,
    parameter int TAG_WIDTH      = 1
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NUMBERS_AMOUNT*NUMBER_WIDTH-1:0] data_i,
    input  logic [TAG_WIDTH-1:0]                   tag_i,
    input  logic                                   data_valid_i,
    output logic                                   ready_o,
    output logic [OUT_WIDTH-1:0]                   data_o,
    output logic [TAG_WIDTH-1:0]                   tag_o,
    output logic                                   sat_o,
    output logic                                   data_valid_o,
    input  logic                                   ready_i
);

    localparam int   LEVELS    = levels_of(NUMBERS_AMOUNT);
    localparam int   POW2      = pow2_of(NUMBERS_AMOUNT);
    localparam logic IS_SIGNED = (SIGNED != 0);
`ifdef PIPELINE_ADDER_TREE_SAT_EN
    localparam logic SAT_EN    = 1'b1;
`else
    localparam logic SAT_EN    = 1'b0;
`endif

    logic [POW2*SUM_WIDTH-1:0] operands;
    logic [POW2*SUM_WIDTH-1:0] data_p0;
    logic [TAG_WIDTH-1:0]      tag_p0;
    logic                      vld_p0;
    logic [LEVELS:0]           valid;
    logic [LEVELS+1:0]         ready;
    logic [SUM_WIDTH-1:0]      final_sum;

    // Extend live operands to full precision; padding slots contribute zero.
    for (genvar i = 0; i < POW2; i++) begin : g_operand
        if (i < NUMBERS_AMOUNT) begin : g_live
            assign operands[i*SUM_WIDTH +: SUM_WIDTH] = SUM_WIDTH'(extend_to_sum(
                MAX_W'(data_i[i*NUMBER_WIDTH +: NUMBER_WIDTH]), NUMBER_WIDTH, IS_SIGNED));
        end else begin : g_pad
            assign operands[i*SUM_WIDTH +: SUM_WIDTH] = '0;
        end
    end

    // Ready ripples back from the consumer; any empty level breaks the stall.
    always_comb begin
        ready = '0;
        ready[LEVELS+1] = ready_i;
        for (int k = LEVELS; k >= 0; k--) begin
            ready[k] = !valid[k] || ready[k+1];
        end
    end

    // Stage 0: operand capture register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
            tag_p0  <= '0;
        end else if (ready[0]) begin
            vld_p0  <= data_valid_i;
            data_p0 <= operands;
            tag_p0  <= tag_i;
        end
    end

    assign valid[0] = vld_p0;
    assign ready_o  = ready[0];

    // Stages 1..LEVELS: each halves the number of partial sums.
    for (genvar k = 1; k <= LEVELS; k++) begin : g_level
        localparam int COUNT = POW2 >> k;
        logic [COUNT*SUM_WIDTH-1:0]   sum;
        logic [TAG_WIDTH-1:0]         tag;
        logic [2*COUNT*SUM_WIDTH-1:0] prev_sum;
        logic [TAG_WIDTH-1:0]         prev_tag;

        if (k == 1) begin : g_first
            assign prev_sum = data_p0;
            assign prev_tag = tag_p0;
        end else begin : g_next
            assign prev_sum = g_level[k-1].sum;
            assign prev_tag = g_level[k-1].tag;
        end

        pipeline_adder_tree_stage #(
            .WIDTH     (SUM_WIDTH),
            .COUNT     (COUNT),
            .TAG_WIDTH (TAG_WIDTH)
        ) u_stage (
            .clk        (clk_i),
            .rst        (rst_i),
            .prev_sum   (prev_sum),
            .prev_tag   (prev_tag),
            .prev_valid (valid[k-1]),
            .next_ready (ready[k+1]),
            .sum        (sum),
            .tag        (tag),
            .valid      (valid[k])
        );
    end

    // Output side: resize is purely combinational on the last level, so a
    // stalled beat keeps data_o/sat_o stable as long as the register holds.
    assign final_sum    = g_level[LEVELS].sum;
    assign tag_o        = g_level[LEVELS].tag;
    assign data_valid_o = valid[LEVELS];
    assign data_o       = OUT_WIDTH'(resize_out(MAX_W'(final_sum), SUM_WIDTH, OUT_WIDTH,
                                                IS_SIGNED, SAT_EN));
`ifdef PIPELINE_ADDER_TREE_SAT_EN
    assign sat_o = resize_clamped(MAX_W'(final_sum), SUM_WIDTH, OUT_WIDTH, IS_SIGNED);
`else
    assign sat_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_adder_tree.sv
// Directed bench for pipeline_adder_tree: three instances cover the unsigned
// 8-operand tree, a signed 5-operand tree with padding, and a narrowed output.
module tb_pipeline_adder_tree;

    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: N=8, W=10, unsigned, 4-bit tag
    logic [79:0] a_data;
    logic [3:0]  a_tag_in, a_tag_out;
    logic        a_vin, a_rdy_out, a_vout, a_rdy_in, a_sat;
    logic [12:0] a_dout;

    // Instance B: N=5, W=10, signed
    logic [49:0] b_data;
    logic        b_tag_in, b_tag_out, b_vin, b_rdy_out, b_vout, b_rdy_in, b_sat;
    logic [12:0] b_dout;

    // Instance C: N=8, W=10, unsigned, 10-bit output
    logic [79:0] c_data;
    logic        c_tag_in, c_tag_out, c_vin, c_rdy_out, c_vout, c_rdy_in, c_sat;
    logic [9:0]  c_dout;

`ifdef PIPELINE_ADDER_TREE_SAT_EN
    localparam int C_BIG_DATA = 1023;
    localparam int C_BIG_SAT  = 1;
`else
    localparam int C_BIG_DATA = 976;
    localparam int C_BIG_SAT  = 0;
`endif

    pipeline_adder_tree #(.NUMBERS_AMOUNT(8), .NUMBER_WIDTH(10), .TAG_WIDTH(4)) dut_a (
        .clk_i(clk), .rst_i(rst), .data_i(a_data), .tag_i(a_tag_in), .data_valid_i(a_vin),
        .ready_o(a_rdy_out), .data_o(a_dout), .tag_o(a_tag_out), .sat_o(a_sat),
        .data_valid_o(a_vout), .ready_i(a_rdy_in));

    pipeline_adder_tree #(.NUMBERS_AMOUNT(5), .NUMBER_WIDTH(10), .SIGNED(1)) dut_b (
        .clk_i(clk), .rst_i(rst), .data_i(b_data), .tag_i(b_tag_in), .data_valid_i(b_vin),
        .ready_o(b_rdy_out), .data_o(b_dout), .tag_o(b_tag_out), .sat_o(b_sat),
        .data_valid_o(b_vout), .ready_i(b_rdy_in));

    pipeline_adder_tree #(.NUMBERS_AMOUNT(8), .NUMBER_WIDTH(10), .OUT_WIDTH(10)) dut_c (
        .clk_i(clk), .rst_i(rst), .data_i(c_data), .tag_i(c_tag_in), .data_valid_i(c_vin),
        .ready_o(c_rdy_out), .data_o(c_dout), .tag_o(c_tag_out), .sat_o(c_sat),
        .data_valid_o(c_vout), .ready_i(c_rdy_in));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // All eight operands equal v.
    function automatic logic [79:0] fill8(input int v);
        logic [79:0] r;
        for (int i = 0; i < 8; i++) r[i*10 +: 10] = 10'(v);
        return r;
    endfunction

    // Beat b: operand i = 10*b + i, so the sum is 80*b + 28.
    function automatic logic [79:0] beat_vec(input int b);
        logic [79:0] r;
        for (int i = 0; i < 8; i++) r[i*10 +: 10] = 10'(b * 10 + i);
        return r;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cnt, tx, rx, rxb, rxc, seen;
        logic        got;
        logic [49:0] b_vec [3];
        logic [12:0] b_exp [3];

        b_vec[0] = {10'd3, 10'd0, 10'h3FF, 10'd511, 10'h200};   // {-512,511,-1,0,3}
        b_vec[1] = {5{10'h200}};                                 // 5 x -512
        b_vec[2] = {5{10'd511}};                                 // 5 x 511
        b_exp[0] = 13'd1;
        b_exp[1] = 13'd5632;                                     // -2560 mod 8192
        b_exp[2] = 13'd2555;

        rst = 1'b1;
        a_data = '0; a_tag_in = '0; a_vin = 1'b0; a_rdy_in = 1'b1;
        b_data = '0; b_tag_in = 1'b0; b_vin = 1'b0; b_rdy_in = 1'b1;
        c_data = '0; c_tag_in = 1'b0; c_vin = 1'b0; c_rdy_in = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_a_valid", 32'(a_vout), 0);
        check("rst_a_data", 32'(a_dout), 0);
        check("rst_a_tag", 32'(a_tag_out), 0);
        check("rst_a_sat", 32'(a_sat), 0);
        check("rst_a_ready", 32'(a_rdy_out), 1);
        check("rst_b_valid", 32'(b_vout), 0);
        check("rst_c_valid", 32'(c_vout), 0);

        // Full-scale operands, latency LEVELS+1 = 4
        a_data = fill8(1023); a_tag_in = 4'd5; a_vin = 1'b1;
        cnt = 0; got = 1'b0;
        while (!got && cnt < 20) begin
            @(posedge clk); cnt++;
            @(negedge clk); a_vin = 1'b0;
            if (a_vout) got = 1'b1;
        end
        check("latency", 32'(cnt), 4);
        check("sum_ones", 32'(a_dout), 8184);
        check("tag_ones", 32'(a_tag_out), 5);
        @(posedge clk); @(negedge clk);
        check("after_ones_empty", 32'(a_vout), 0);

        // 16-beat stream with ready_i toggling 1,0,1,0...
        tx = 0; rx = 0;
        for (int cyc = 0; cyc < 200 && rx < 16; cyc++) begin
            a_rdy_in = (cyc % 2 == 0);
            a_vin    = (tx < 16);
            a_data   = beat_vec(tx);
            a_tag_in = 4'(tx);
            #1;
            if (a_vout && a_rdy_in) begin
                check("stream_sum", 32'(a_dout), 32'(80 * rx + 28));
                check("stream_tag", 32'(a_tag_out), 32'(rx & 15));
                rx++;
            end
            if (a_vin && a_rdy_out) tx++;
            @(posedge clk); @(negedge clk);
        end
        check("stream_count", 32'(rx), 16);

        // Downstream stalled for 10 cycles while the source keeps offering beats
        a_vin = 1'b0; a_rdy_in = 1'b1;
        @(posedge clk); @(negedge clk);
        tx = 16; a_rdy_in = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            a_vin = 1'b1; a_data = beat_vec(tx); a_tag_in = 4'(tx);
            #1;
            if (a_vout) begin
                check("stall_hold_data", 32'(a_dout), 32'(80 * 16 + 28));
                check("stall_hold_tag", 32'(a_tag_out), 0);
            end
            if (a_vin && a_rdy_out) tx++;
            @(posedge clk); @(negedge clk);
        end
        check("stall_accepted", 32'(tx - 16), 4);
        check("stall_ready_low", 32'(a_rdy_out), 0);
        check("stall_valid", 32'(a_vout), 1);

        // Release and drain in order
        a_vin = 1'b0; a_rdy_in = 1'b1; rx = 16;
        for (int cyc = 0; cyc < 20 && rx < 24; cyc++) begin
            #1;
            if (a_vout) begin
                check("drain_sum", 32'(a_dout), 32'(80 * rx + 28));
                check("drain_tag", 32'(a_tag_out), 32'(rx & 15));
                rx++;
            end
            @(posedge clk); @(negedge clk);
        end
        check("drain_count", 32'(rx), 20);

        // Reset with 3 beats in flight
        for (int b = 0; b < 3; b++) begin
            a_vin = 1'b1; a_data = fill8(1); a_tag_in = 4'(b);
            @(posedge clk); @(negedge clk);
        end
        a_vin = 1'b0; rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check("flush_valid", 32'(a_vout), 0);
        check("flush_ready", 32'(a_rdy_out), 1);
        check("flush_data", 32'(a_dout), 0);
        rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(posedge clk); @(negedge clk);
            if (a_vout) seen++;
        end
        check("flush_no_stale", 32'(seen), 0);

        // Signed tree with padding (B) and narrowed output (C)
        rxb = 0; rxc = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            b_vin    = (cyc < 3);
            b_data   = b_vec[(cyc < 3) ? cyc : 0];
            b_tag_in = 1'(cyc);
            c_vin    = (cyc < 2);
            c_data   = (cyc == 0) ? fill8(250) : fill8(125);
            #1;
            if (b_vout) begin
                if (rxb < 3) begin
                    check("signed_sum", 32'(b_dout), 32'(b_exp[rxb]));
                    check("signed_tag", 32'(b_tag_out), 32'(rxb & 1));
                end
                rxb++;
            end
            if (c_vout) begin
                if (rxc == 0) begin
                    check("narrow_big_data", 32'(c_dout), C_BIG_DATA);
                    check("narrow_big_sat", 32'(c_sat), C_BIG_SAT);
                end else begin
                    check("narrow_fit_data", 32'(c_dout), 1000);
                    check("narrow_fit_sat", 32'(c_sat), 0);
                end
                rxc++;
            end
            @(posedge clk); @(negedge clk);
        end
        check("signed_count", 32'(rxb), 3);
        check("narrow_count", 32'(rxc), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
